// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter between two byte producers.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: fixed priority).
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_busy_i,
  output logic       grant_o,
  output logic       active_o,
  output logic       err_o
);

  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          cnt_hit;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          grant_q, grant_d;
  logic          active_q, active_d;
  logic          err_q, err_d;
  logic          tie1;
  logic          pick1;
  logic          elig;

  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_hit = (cnt_inc == CNT_LAST);

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic rr_seen_q;

  // Remember the first grant so that ties alternate from then on.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_seen_q <= 1'b0;
    end else if (req0_ready_o | req1_ready_o) begin
      rr_seen_q <= 1'b1;
    end
  end

  assign tie1 = rr_seen_q & ~grant_q;
`else
  assign tie1 = 1'b0;
`endif

  assign pick1 = req1_valid_i & (~req0_valid_i | tie1);
  assign elig  = (state_q == IDLE) & ~tx_busy_i &
                 (req0_valid_i | req1_valid_i);

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      grant_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (elig) state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy_i)    state_d = WAIT_DONE;
        else if (cnt_hit) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshakes and next values of the registered outputs.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    start_d      = 1'b0;
    data_d       = data_q;
    grant_d      = grant_q;
    active_d     = active_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (elig) begin
          req0_ready_o = ~pick1;
          req1_ready_o = pick1;
          start_d      = 1'b1;
          data_d       = pick1 ? req1_data_i : req0_data_i;
          grant_d      = pick1;
          active_d     = 1'b1;
        end
      end
      START: begin
        cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (!tx_busy_i) begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            err_d    = 1'b1;
            active_d = 1'b0;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) active_d = 1'b0;
      end
      default: begin
        active_d = 1'b0;
      end
    endcase
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign grant_o    = grant_q;
  assign active_o   = active_q;
  assign err_o      = err_q;

endmodule
